scroll_datapath: RTL and testbench

- Datapath and timing stage directly downstream of the scrolling-text control FSM.
- Consumes its strobes: restart, draw1..draw4, delay and update.
- Generates tile-RAM addresses and VGA plot coordinates, and copies tiles between letter RAMs during a scroll update.
- Returns the handshake flags finish_draw1..finish_draw4, finish_delay and finish_update that advance that FSM.

---
 rtl/scroll_pkg.sv | 28 ++
 rtl/scroll_tile_scanner.sv | 51 +++++
 rtl/scroll_datapath.sv | 130 +++++++++++++
 tb/tb_scroll_datapath.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scroll_pkg.sv
// Shared constants, scan-mode encoding and slot geometry helper for the
// scrolling-text datapath.
package scroll_pkg;

   localparam int unsigned X_W        = 8;
   localparam int unsigned Y_W        = 7;
   localparam int unsigned NUM_SLOTS  = 4;

   localparam int unsigned TILE_W_DEF = 16;
   localparam int unsigned TILE_H_DEF = 16;
   localparam int unsigned X0_DEF     = 16;
   localparam int unsigned SLOT_W_DEF = 32;
   localparam int unsigned Y0_DEF     = 52;

   typedef enum logic [1:0] {
      MODE_IDLE,
      MODE_DRAW,
      MODE_UPDATE
   } scan_mode_t;

   // x origin of a zero-based slot index, truncated to screen width
   function automatic logic [X_W-1:0] slot_x(input logic [1:0] slot,
                                              input int unsigned x0,
                                              input int unsigned pitch);
      return X_W'(x0 + 32'(slot) * pitch);
   endfunction

endpackage

// File: rtl/scroll_tile_scanner.sv
// Tile address counter shared by draw and update. Issues addresses 0..N-1
// once per restart, exposes the read address, its one-cycle-delayed copy
// (aligned with RAM read data) and the column/row split of the current
// address.
module scroll_tile_scanner
   import scroll_pkg::*;
#(
   parameter int unsigned TILE_W = TILE_W_DEF,
   parameter int unsigned TILE_H = TILE_H_DEF,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              run,
   output logic              issue,
   output logic              last,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [X_W-1:0]    col,
   output logic [Y_W-1:0]    row
);

   localparam int unsigned N = TILE_W * TILE_H;

   logic [ADDR_W-1:0] k;
   logic              spent;

   // spent blocks re-issuing the final address while the request stays high
   assign issue   = run && !clear && !spent;
   assign last    = (k == ADDR_W'(N - 1));
   assign rd_addr = k;
   assign col     = X_W'(k % TILE_W);
   assign row     = Y_W'(k / TILE_W);

   // address counter (saturating) and one-cycle alignment register
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         k       <= '0;
         spent   <= 1'b0;
         wr_addr <= '0;
      end else begin
         wr_addr <= k;
         if (issue) begin
            if (last) spent <= 1'b1;
            else      k     <= k + 1'b1;
         end
      end
   end

endmodule

// File: rtl/scroll_datapath.sv
// Datapath below the scrolling-text FSM: tile scan for draw/update,
// registered VGA plot coordinates, RAM copy strobes, delay timer and the
// finish handshakes back to the FSM.
module scroll_datapath
   import scroll_pkg::*;
#(
   parameter int unsigned TILE_W       = TILE_W_DEF,
   parameter int unsigned TILE_H       = TILE_H_DEF,
   parameter int unsigned ADDR_W       = 8,
   parameter int unsigned X0           = X0_DEF,
   parameter int unsigned SLOT_W       = SLOT_W_DEF,
   parameter int unsigned Y0           = Y0_DEF,
   parameter int unsigned DELAY_CYCLES = 50000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              restart,
   input  logic              draw1,
   input  logic              draw2,
   input  logic              draw3,
   input  logic              draw4,
   input  logic              delay,
   input  logic              update,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              wr_valid,
   output logic [X_W-1:0]    x,
   output logic [Y_W-1:0]    y,
   output logic              plot,
   output logic              finish_draw1,
   output logic              finish_draw2,
   output logic              finish_draw3,
   output logic              finish_draw4,
   output logic              finish_delay,
   output logic              finish_update
);

   localparam int unsigned D_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

   logic [NUM_SLOTS-1:0] draw_req;
   logic [NUM_SLOTS-1:0] fin_draw;
   logic [1:0]           sel;
   scan_mode_t           mode;
   logic                 run;
   logic                 issue;
   logic                 last;
   logic [X_W-1:0]       col;
   logic [Y_W-1:0]       row;
   logic [D_W-1:0]       d;

   assign draw_req      = {draw4, draw3, draw2, draw1};
   assign finish_draw1  = fin_draw[0];
   assign finish_draw2  = fin_draw[1];
   assign finish_draw3  = fin_draw[2];
   assign finish_draw4  = fin_draw[3];

   // slot select (lowest wins), draw over update, and finished-request gating
   always_comb begin
      sel = 2'd0;
      if      (draw_req[0]) sel = 2'd0;
      else if (draw_req[1]) sel = 2'd1;
      else if (draw_req[2]) sel = 2'd2;
      else if (draw_req[3]) sel = 2'd3;
      mode = MODE_IDLE;
      if (|draw_req)   mode = MODE_DRAW;
      else if (update) mode = MODE_UPDATE;
      run = 1'b0;
      case (mode)
         MODE_DRAW:   run = !fin_draw[sel];
         MODE_UPDATE: run = !finish_update;
         default:     run = 1'b0;
      endcase
   end

   scroll_tile_scanner #(
      .TILE_W (TILE_W),
      .TILE_H (TILE_H),
      .ADDR_W (ADDR_W)
   ) u_scanner (
      .clk     (clk),
      .reset   (reset),
      .clear   (restart),
      .run     (run),
      .issue   (issue),
      .last    (last),
      .rd_addr (rd_addr),
      .wr_addr (wr_addr),
      .col     (col),
      .row     (row)
   );

   // plot/copy strobes, coordinates and scan finish flags, one stage after issue
   always_ff @(posedge clk) begin
      if (reset) begin
         plot          <= 1'b0;
         wr_valid      <= 1'b0;
         x             <= '0;
         y             <= '0;
         fin_draw      <= '0;
         finish_update <= 1'b0;
      end else if (restart) begin
         plot          <= 1'b0;
         wr_valid      <= 1'b0;
         fin_draw      <= '0;
         finish_update <= 1'b0;
      end else begin
         plot     <= issue && (mode == MODE_DRAW);
         wr_valid <= issue && (mode == MODE_UPDATE);
         if (issue && (mode == MODE_DRAW)) begin
            x <= slot_x(sel, X0, SLOT_W) + col;
            y <= Y_W'(Y0) + row;
            if (last) fin_draw[sel] <= 1'b1;
         end
         if (issue && (mode == MODE_UPDATE) && last) finish_update <= 1'b1;
      end
   end

   // delay timer: saturating count while delay is held, flag registered on terminal count
   always_ff @(posedge clk) begin
      if (reset || restart) begin
         d            <= '0;
         finish_delay <= 1'b0;
      end else begin
         finish_delay <= delay && (d == D_W'(DELAY_CYCLES - 1));
         if (!delay)                             d <= '0;
         else if (d != D_W'(DELAY_CYCLES - 1))   d <= d + 1'b1;
      end
   end

endmodule

// File: tb/tb_scroll_datapath.sv
// Self-checking bench for scroll_datapath with a small 4x2 tile and a short
// delay interval. Per-cycle expectations come from a vector table; a few
// hand-written sequences cover restart priority and delay saturation.
module tb_scroll_datapath;

   logic       clk = 1'b0;
   logic       reset, restart, delay, update;
   logic [3:0] draw;
   logic [7:0] rd_addr, wr_addr;
   logic       wr_valid, plot;
   logic [7:0] x;
   logic [6:0] y;
   logic       finish_draw1, finish_draw2, finish_draw3, finish_draw4;
   logic       finish_delay, finish_update;

   int unsigned tests  = 0;
   int unsigned failed = 0;

   always #5 clk = ~clk;

   scroll_datapath #(
      .TILE_W       (4),
      .TILE_H       (2),
      .ADDR_W       (8),
      .X0           (16),
      .SLOT_W       (32),
      .Y0           (52),
      .DELAY_CYCLES (5)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .restart       (restart),
      .draw1         (draw[0]),
      .draw2         (draw[1]),
      .draw3         (draw[2]),
      .draw4         (draw[3]),
      .delay         (delay),
      .update        (update),
      .rd_addr       (rd_addr),
      .wr_addr       (wr_addr),
      .wr_valid      (wr_valid),
      .x             (x),
      .y             (y),
      .plot          (plot),
      .finish_draw1  (finish_draw1),
      .finish_draw2  (finish_draw2),
      .finish_draw3  (finish_draw3),
      .finish_draw4  (finish_draw4),
      .finish_delay  (finish_delay),
      .finish_update (finish_update)
   );

   typedef struct {
      logic       chk;
      logic       reset, restart;
      logic [3:0] draw;
      logic       delay, update;
      logic       chk_addr;
      logic [7:0] rd_addr;
      logic       chk_wr;
      logic [7:0] wr_addr;
      logic       wr_valid;
      logic       plot;
      logic       chk_xy;
      logic [7:0] x;
      logic [6:0] y;
      logic [3:0] fdraw;
      logic       fdelay, fupd;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t blank();
      vec_t v;
      v = '{default: '0};
      return v;
   endfunction

   // a scan started right after restart/reset: addresses 0..7, outputs one cycle later
   task automatic add_scan(input int n, input logic [3:0] dr, input logic up,
                           input int x0, input int fbit, input logic is_draw);
      for (int c = 0; c < n; c++) begin
         vec_t v;
         logic act;
         v          = blank();
         v.chk      = 1'b1;
         v.draw     = dr;
         v.update   = up;
         v.chk_addr = 1'b1;
         v.rd_addr  = 8'((c < 7) ? c : 7);
         v.chk_wr   = 1'b1;
         v.wr_addr  = 8'((c == 0) ? 0 : ((c - 1 < 7) ? c - 1 : 7));
         act        = (c >= 1) && (c <= 8);
         if (is_draw) begin
            v.plot   = act;
            v.chk_xy = act;
            if (act) begin
               v.x = 8'(x0 + (c - 1) % 4);
               v.y = 7'(52 + (c - 1) / 4);
            end
            if (c >= 8) v.fdraw[fbit] = 1'b1;
         end else begin
            v.wr_valid = act;
            if (c >= 8) v.fupd = 1'b1;
         end
         vecs.push_back(v);
      end
   endtask

   task automatic add_ctl(input logic rst, input logic rs, input logic [3:0] dr);
      vec_t v;
      v         = blank();
      v.reset   = rst;
      v.restart = rs;
      v.draw    = dr;
      vecs.push_back(v);
   endtask

   task automatic compare_vec(input int idx, input vec_t e);
      string p;
      p = $sformatf("v%0d", idx);
      if (e.chk_addr) chk({p, " rd_addr"}, rd_addr, e.rd_addr);
      if (e.chk_wr)   chk({p, " wr_addr"}, wr_addr, e.wr_addr);
      chk({p, " wr_valid"}, wr_valid, e.wr_valid);
      chk({p, " plot"}, plot, e.plot);
      if (e.chk_xy) begin
         chk({p, " x"}, x, e.x);
         chk({p, " y"}, y, e.y);
      end
      chk({p, " finish_draw"}, {finish_draw4, finish_draw3, finish_draw2, finish_draw1}, e.fdraw);
      chk({p, " finish_delay"}, finish_delay, e.fdelay);
      chk({p, " finish_update"}, finish_update, e.fupd);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   base;
      int   n_plot;
      int   n_fd;
      logic done;

      // ---- build vector table ----
      // reset state
      for (int i = 0; i < 2; i++) begin
         v = blank(); v.chk = 1'b1; v.reset = 1'b1; v.chk_addr = 1'b1; v.chk_wr = 1'b1;
         v.chk_xy = 1'b1;
         vecs.push_back(v);
      end
      // delay high cycles 0..7, low from cycle 8
      for (int c = 0; c < 10; c++) begin
         v = blank(); v.chk = 1'b1; v.chk_addr = 1'b1; v.chk_wr = 1'b1;
         v.delay  = (c <= 7);
         v.fdelay = (c >= 5) && (c <= 8);
         vecs.push_back(v);
      end
      // draw2
      add_ctl(1'b0, 1'b1, 4'b0000);
      add_scan(11, 4'b0010, 1'b0, 48, 1, 1'b1);
      // update, then restart clears finish_update
      add_ctl(1'b0, 1'b1, 4'b0000);
      add_scan(11, 4'b0000, 1'b1, 0, 0, 1'b0);
      add_ctl(1'b0, 1'b1, 4'b0000);
      v = blank(); v.chk = 1'b1; v.chk_addr = 1'b1; v.chk_wr = 1'b1;
      vecs.push_back(v);
      // draw1+draw3 (and update) together: slot 1 wins, draw beats update
      add_ctl(1'b0, 1'b1, 4'b0000);
      add_scan(12, 4'b0101, 1'b1, 16, 0, 1'b1);
      // draw4 with reset asserted during cycle 3
      add_ctl(1'b0, 1'b1, 4'b0000);
      add_scan(3, 4'b1000, 1'b0, 112, 3, 1'b1);
      v = blank(); v.chk = 1'b1; v.reset = 1'b1; v.draw = 4'b1000;
      v.chk_addr = 1'b1; v.rd_addr = 8'd3; v.chk_wr = 1'b1; v.wr_addr = 8'd2;
      v.plot = 1'b1; v.chk_xy = 1'b1; v.x = 8'd114; v.y = 7'd52;
      vecs.push_back(v);
      base = vecs.size();
      add_scan(11, 4'b1000, 1'b0, 112, 3, 1'b1);
      vecs[base].chk_xy = 1'b1;
      vecs[base].x      = 8'd0;
      vecs[base].y      = 7'd0;

      // ---- apply ----
      reset = 1'b1; restart = 1'b0; draw = 4'b0000; delay = 1'b0; update = 1'b0;
      repeat (3) @(posedge clk);
      foreach (vecs[i]) begin
         vec_t e;
         @(posedge clk); #1;
         reset   = vecs[i].reset;
         restart = vecs[i].restart;
         draw    = vecs[i].draw;
         delay   = vecs[i].delay;
         update  = vecs[i].update;
         if (vecs[i].chk) sb.push_back(vecs[i]);
         @(negedge clk);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            compare_vec(i, e);
         end
      end

      // ---- restart wins over a simultaneous draw request ----
      @(posedge clk); #1;
      reset = 1'b0; restart = 1'b1; draw = 4'b0001; delay = 1'b0; update = 1'b0;
      @(posedge clk); #1;
      restart = 1'b0;
      @(negedge clk);
      chk("restart_prio plot", plot, 0);
      chk("restart_prio rd_addr", rd_addr, 0);
      chk("restart_prio finish_draw4", finish_draw4, 0);
      n_plot = 0;
      done   = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (plot) n_plot++;
         if (finish_draw1) done = 1'b1;
      end
      chk("draw1 finished within budget", done, 1);
      chk("draw1 plot count", n_plot, 8);
      @(negedge clk);
      chk("draw1 held plot", plot, 0);
      chk("draw1 held rd_addr", rd_addr, 7);

      // ---- delay held long: finish_delay stays high, counter saturates ----
      @(posedge clk); #1;
      draw = 4'b0000; delay = 1'b1;
      n_fd = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (finish_delay) n_fd++;
      end
      chk("delay hold count", n_fd, 25);
      chk("delay hold level", finish_delay, 1);
      @(posedge clk); #1;
      delay = 1'b0;
      @(negedge clk);
      chk("delay drop edge", finish_delay, 1);
      @(negedge clk);
      chk("delay dropped", finish_delay, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
